// File: rtl/rtc_hms_set_if.sv
// Control inputs and display outputs of the time-of-day keeper.
// master drives the controls, slave is the keeper itself.
interface rtc_hms_set_if;
    logic       iRun;
    logic       iSetMode;
    logic       iSetSel;
    logic       iSetInc;
    logic       iMode12;
    logic [3:0] oHourTens;
    logic [3:0] oHourOnes;
    logic [3:0] oMinTens;
    logic [3:0] oMinOnes;
    logic [3:0] oSecTens;
    logic [3:0] oSecOnes;
    logic       oPm;
    logic [1:0] oSelField;
    logic       oBlink;
    logic       oSecStrb;
    logic       oDayStrb;

    modport master (
        output iRun, iSetMode, iSetSel, iSetInc, iMode12,
        input  oHourTens, oHourOnes, oMinTens, oMinOnes,
        input  oSecTens, oSecOnes, oPm, oSelField,
        input  oBlink, oSecStrb, oDayStrb
    );

    modport slave (
        input  iRun, iSetMode, iSetSel, iSetInc, iMode12,
        output oHourTens, oHourOnes, oMinTens, oMinOnes,
        output oSecTens, oSecOnes, oPm, oSelField,
        output oBlink, oSecStrb, oDayStrb
    );
endinterface

// File: rtl/rtc_hms_set.sv
// Time-of-day keeper: prescaler, run/hold, key-driven set mode,
// 12/24h BCD display, second and day strobes.
module rtc_hms_set #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input logic         iClk,
    input logic         iRst,
    rtc_hms_set_if.slave bus
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] HALF = PW'(TICKS_PER_SEC / 2);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [4:0]    hr;
    logic [5:0]    mn;
    logic [5:0]    sc;
    logic          sec_strb;
    logic          day_strb;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= RUN;
            presc    <= '0;
            hr       <= '0;
            mn       <= '0;
            sc       <= '0;
            sec_strb <= 1'b0;
            day_strb <= 1'b0;
        end else begin
            sec_strb <= 1'b0;
            day_strb <= 1'b0;
            unique case (state)
                RUN: begin
                    if (bus.iRun) begin
                        if (presc == LAST) begin
                            presc    <= '0;
                            sec_strb <= 1'b1;
                            if (sc == 6'd59) begin
                                sc <= '0;
                                if (mn == 6'd59) begin
                                    mn <= '0;
                                    if (hr == 5'd23) begin
                                        hr       <= '0;
                                        day_strb <= 1'b1;
                                    end else begin
                                        hr <= hr + 5'd1;
                                    end
                                end else begin
                                    mn <= mn + 6'd1;
                                end
                            end else begin
                                sc <= sc + 6'd1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    if (bus.iSetMode) state <= SET_H;
                end
                SET_H, SET_M, SET_S: begin
                    if (!bus.iSetMode) begin
                        // restart the second so the first one after setting is full length
                        state <= RUN;
                        presc <= '0;
                    end else begin
                        presc <= (presc == LAST) ? '0 : presc + PW'(1);
                        if (bus.iSetInc) begin
                            presc <= '0;
                            unique case (state)
                                SET_H:   hr <= (hr == 5'd23) ? '0 : hr + 5'd1;
                                SET_M:   mn <= (mn == 6'd59) ? '0 : mn + 6'd1;
                                default: sc <= (sc == 6'd59) ? '0 : sc + 6'd1;
                            endcase
                        end
                        if (bus.iSetSel) begin
                            unique case (state)
                                SET_H:   state <= SET_M;
                                SET_M:   state <= SET_S;
                                default: state <= SET_H;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    logic [4:0] h12;
    logic [4:0] hdisp;

    always_comb begin
        h12 = hr;
        if (hr == 5'd0)
            h12 = 5'd12;
        else if (hr > 5'd12)
            h12 = hr - 5'd12;
        hdisp = bus.iMode12 ? h12 : hr;
    end

    assign bus.oHourTens = 4'(hdisp / 5'd10);
    assign bus.oHourOnes = 4'(hdisp % 5'd10);
    assign bus.oMinTens  = 4'(mn / 6'd10);
    assign bus.oMinOnes  = 4'(mn % 6'd10);
    assign bus.oSecTens  = 4'(sc / 6'd10);
    assign bus.oSecOnes  = 4'(sc % 6'd10);
    assign bus.oPm       = bus.iMode12 && (hr >= 5'd12);
    assign bus.oSelField = state;
    assign bus.oBlink    = (state != RUN) && (presc >= HALF);
    assign bus.oSecStrb  = sec_strb;
    assign bus.oDayStrb  = day_strb;
endmodule
